// File: rtl/spi_controller_if.sv
// Request/response and SPI line bundle for spi_controller.
// The controller uses the slave modport; whoever requests frames uses master.
interface spi_controller_if;
   logic       start;
   logic       cmd_write;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic       SCLK;
   logic       nCS;
   logic       COPI;

   modport slave (
      input  start, cmd_write, addr, wdata,
      output busy, done, SCLK, nCS, COPI
   );

   modport master (
      output start, cmd_write, addr, wdata,
      input  busy, done, SCLK, nCS, COPI
   );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: shifts {cmd_write, addr, wdata} MSB-first under nCS/SCLK.
// All serial lines come straight from flops, so SCLK and nCS cannot glitch.
module spi_controller #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic            clk,
   input  logic            rst,
   spi_controller_if.slave bus
);

   localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W  = $clog2(MAXC + 1);

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   // The done/idle cycle itself is the last high cycle of the inter-frame gap.
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       bitcnt_q, bitcnt_d;
   logic [15:0]      shreg_q, shreg_d;
   logic             sclk_q, sclk_d;
   logic             ncs_q, ncs_d;
   logic             copi_q, copi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               shreg_d  = {bus.cmd_write, bus.addr, bus.wdata};
               bitcnt_d = '0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d    = '0;
               bitcnt_d = bitcnt_q + 5'd1;
               if (bitcnt_q == 5'd15) begin
                  state_d = S_HOLD;
               end else begin
                  // Shift on the falling edge so COPI settles a full half-period before the rise.
                  shreg_d = {shreg_q[14:0], 1'b0};
                  state_d = S_LOW;
               end
            end
         end
         S_LOW: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = '0;
               state_d = S_HIGH;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Line values are decoded from the next state and registered with it.
      ncs_d  = !(state_d inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
      sclk_d = (state_d == S_HIGH);
      copi_d = (state_d inside {S_SETUP, S_HIGH, S_LOW}) ? shreg_d[15] : 1'b0;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         sclk_q   <= 1'b0;
         ncs_q    <= 1'b1;
         copi_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         sclk_q   <= sclk_d;
         ncs_q    <= ncs_d;
         copi_q   <= copi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign bus.SCLK = sclk_q;
   assign bus.nCS  = ncs_q;
   assign bus.COPI = copi_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: two controllers (default and minimum timing) each feeding a
// behavioural register-write peripheral model that also measures line timing.
module tb_spi_controller;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   spi_controller_if bus_a ();
   spi_controller_if bus_b ();

   spi_controller dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   spi_controller #(.CLK_DIV(2), .CS_IDLE(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] sclk_v, ncs_v, copi_v, busy_v, done_v;
   assign sclk_v = {bus_b.SCLK, bus_a.SCLK};
   assign ncs_v  = {bus_b.nCS,  bus_a.nCS};
   assign copi_v = {bus_b.COPI, bus_a.COPI};
   assign busy_v = {bus_b.busy, bus_a.busy};
   assign done_v = {bus_b.done, bus_a.done};

   // Peripheral model: regs 0..4 written on nCS rise after exactly 16 rises with bit15=1.
   for (genvar g = 0; g < 2; g++) begin : mon
      logic [15:0] rx = '0;
      logic [15:0] last_frame = '0;
      logic [7:0]  regs [5] = '{default: 8'h00};
      logic [2:0]  widx;
      logic        sclk_p = 1'b0, ncs_p = 1'b1, copi_p = 1'b0;
      bit          seen_fall = 1'b0;
      int rises = 0, last_rises = 0, low_cnt = 0, high_cnt = 0;
      int last_low = 0, last_high = 0, dones = 0, frames = 0, viol = 0;
      int hi_run = 0, lo_run = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

      initial forever begin
         @(negedge clk);
         if (sclk_v[g] && !sclk_p) begin
            rx = {rx[14:0], copi_v[g]};
            rises++;
            if (seen_fall) begin
               if (lo_run < lo_min) lo_min = lo_run;
               if (lo_run > lo_max) lo_max = lo_run;
            end
            hi_run = 0;
         end
         if (!sclk_v[g] && sclk_p) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            seen_fall = 1'b1;
            lo_run = 0;
         end
         if (sclk_v[g]) hi_run++; else lo_run++;

         if (ncs_v[g] && !ncs_p) begin
            last_low   = low_cnt;
            last_frame = rx;
            last_rises = rises;
            frames++;
            widx = rx[10:8];
            if (rises == 16 && rx[15] && rx[14:8] < 7'd5) regs[widx] = rx[7:0];
            low_cnt  = 0;
            high_cnt = 0;
         end
         if (!ncs_v[g] && ncs_p) begin
            last_high = high_cnt;
            high_cnt  = 0;
            low_cnt   = 0;
            rises     = 0;
            seen_fall = 1'b0;
         end
         if (ncs_v[g]) high_cnt++; else low_cnt++;

         if (sclk_v[g] && ncs_v[g]) viol++;
         if (sclk_v[g] && sclk_p && copi_v[g] != copi_p) viol++;
         if (!ncs_v[g] && !busy_v[g]) viol++;
         if (done_v[g]) dones++;

         sclk_p = sclk_v[g];
         ncs_p  = ncs_v[g];
         copi_p = copi_v[g];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input bit which, input logic cw, input logic [6:0] a, input logic [7:0] d);
      if (which) begin
         bus_b.cmd_write = cw; bus_b.addr = a; bus_b.wdata = d; bus_b.start = 1'b1;
      end else begin
         bus_a.cmd_write = cw; bus_a.addr = a; bus_a.wdata = d; bus_a.start = 1'b1;
      end
      tick();
      // Scramble the data inputs: only the accept cycle may matter.
      if (which) begin
         bus_b.start = 1'b0; bus_b.addr = 7'h55; bus_b.wdata = 8'h00; bus_b.cmd_write = 1'b0;
      end else begin
         bus_a.start = 1'b0; bus_a.addr = 7'h55; bus_a.wdata = 8'h00; bus_a.cmd_write = 1'b0;
      end
   endtask

   task automatic wait_done(input bit which, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (done_v[which]) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 1);
   endtask

   initial begin
      bit found;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus_a.start = 1'b0; bus_a.cmd_write = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
      bus_b.start = 1'b0; bus_b.cmd_write = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
      repeat (3) tick();
      chk("rst_ncs",  32'(bus_a.nCS),  1);
      chk("rst_sclk", 32'(bus_a.SCLK), 0);
      chk("rst_copi", 32'(bus_a.COPI), 0);
      chk("rst_busy", 32'(bus_a.busy), 0);
      chk("rst_done", 32'(bus_a.done), 0);
      rst = 1'b0;
      tick();

      // 1: write 0x04 <- 0x80
      go(1'b0, 1'b1, 7'h04, 8'h80);
      chk("t1_first_ncs",  32'(bus_a.nCS),  0);
      chk("t1_first_busy", 32'(bus_a.busy), 1);
      chk("t1_first_copi", 32'(bus_a.COPI), 1);
      chk("t1_first_sclk", 32'(bus_a.SCLK), 0);
      wait_done(1'b0, "t1_done_seen");
      chk("t1_busy_on_done", 32'(bus_a.busy), 0);
      chk("t1_frame", 32'(mon[0].last_frame), 32'h8480);
      chk("t1_ncs_low", mon[0].last_low, 128);
      chk("t1_rises", mon[0].last_rises, 16);
      chk("t1_reg4", 32'(mon[0].regs[4]), 32'h80);
      chk("t1_dones", mon[0].dones, 1);
      tick();
      chk("t1_done_pulse", 32'(bus_a.done), 0);

      // 2: back-to-back frames, second start on the done cycle
      go(1'b0, 1'b1, 7'h00, 8'hA5);
      wait_done(1'b0, "t2a_done_seen");
      go(1'b0, 1'b1, 7'h01, 8'h3C);
      wait_done(1'b0, "t2b_done_seen");
      chk("t2_gap", mon[0].last_high, 4);
      chk("t2_frame", 32'(mon[0].last_frame), 32'h813C);
      chk("t2_reg0", 32'(mon[0].regs[0]), 32'hA5);
      chk("t2_reg1", 32'(mon[0].regs[1]), 32'h3C);
      chk("t2_dones", mon[0].dones, 3);

      // 3: start mid-frame is ignored
      go(1'b0, 1'b1, 7'h02, 8'h5A);
      repeat (9) tick();
      go(1'b0, 1'b1, 7'h01, 8'hFF);
      wait_done(1'b0, "t3_done_seen");
      chk("t3_frame", 32'(mon[0].last_frame), 32'h825A);
      repeat (200) tick();
      chk("t3_dones", mon[0].dones, 4);
      chk("t3_frames", mon[0].frames, 4);
      chk("t3_reg1", 32'(mon[0].regs[1]), 32'h3C);
      chk("t3_reg2", 32'(mon[0].regs[2]), 32'h5A);

      // 4: reset after the 7th SCLK rise aborts the frame
      go(1'b0, 1'b1, 7'h02, 8'h77);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (mon[0].rises == 7) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t4_reached_7", 32'(found), 1);
      rst = 1'b1;
      tick();
      chk("t4_ncs",  32'(bus_a.nCS),  1);
      chk("t4_sclk", 32'(bus_a.SCLK), 0);
      chk("t4_copi", 32'(bus_a.COPI), 0);
      chk("t4_busy", 32'(bus_a.busy), 0);
      chk("t4_done", 32'(bus_a.done), 0);
      rst = 1'b0;
      repeat (20) tick();
      chk("t4_no_done", mon[0].dones, 4);
      chk("t4_no_commit", 32'(mon[0].regs[2]), 32'h5A);
      go(1'b0, 1'b1, 7'h02, 8'h11);
      wait_done(1'b0, "t4_done_seen");
      chk("t4_reg2", 32'(mon[0].regs[2]), 32'h11);
      chk("t4_reg0", 32'(mon[0].regs[0]), 32'hA5);
      chk("t4_reg1", 32'(mon[0].regs[1]), 32'h3C);
      chk("t4_reg4", 32'(mon[0].regs[4]), 32'h80);
      chk("t4_dones", mon[0].dones, 5);

      // 5: read command is not a write
      go(1'b0, 1'b0, 7'h03, 8'hFF);
      wait_done(1'b0, "t5_done_seen");
      chk("t5_frame", 32'(mon[0].last_frame), 32'h03FF);
      chk("t5_dones", mon[0].dones, 6);
      chk("t5_reg3", 32'(mon[0].regs[3]), 32'h00);
      chk("a_line_viol", mon[0].viol, 0);

      // 6: minimum timing, all addresses plus an out-of-range one
      go(1'b1, 1'b1, 7'h00, 8'h11);
      wait_done(1'b1, "t6_done0");
      go(1'b1, 1'b1, 7'h01, 8'h22);
      wait_done(1'b1, "t6_done1");
      go(1'b1, 1'b1, 7'h02, 8'h33);
      wait_done(1'b1, "t6_done2");
      go(1'b1, 1'b1, 7'h03, 8'h44);
      wait_done(1'b1, "t6_done3");
      go(1'b1, 1'b1, 7'h04, 8'h55);
      wait_done(1'b1, "t6_done4");
      go(1'b1, 1'b1, 7'h7F, 8'hEE);
      wait_done(1'b1, "t6_done5");
      chk("t6_reg0", 32'(mon[1].regs[0]), 32'h11);
      chk("t6_reg1", 32'(mon[1].regs[1]), 32'h22);
      chk("t6_reg2", 32'(mon[1].regs[2]), 32'h33);
      chk("t6_reg3", 32'(mon[1].regs[3]), 32'h44);
      chk("t6_reg4", 32'(mon[1].regs[4]), 32'h55);
      chk("t6_frame", 32'(mon[1].last_frame), 32'hFFEE);
      chk("t6_ncs_low", mon[1].last_low, 66);
      chk("t6_gap", mon[1].last_high, 2);
      chk("t6_hi_min", mon[1].hi_min, 2);
      chk("t6_hi_max", mon[1].hi_max, 2);
      chk("t6_lo_min", mon[1].lo_min, 2);
      chk("t6_lo_max", mon[1].lo_max, 2);
      chk("t6_dones", mon[1].dones, 6);
      chk("b_line_viol", mon[1].viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
